// File: rtl/adc_frame_pkg.sv
// Shared constants and FSM state types for the AD7768-4 frame serializer.
// Imported by adc_in_sync and adc_frame_serializer.
package adc_frame_pkg;

  localparam int CH_BITS_DEF = 32;
  localparam int N_CH_DEF    = 4;
  localparam int HDR_BITS    = 8;
  localparam int FRAME_BITS  = CH_BITS_DEF * N_CH_DEF;

  typedef enum logic {
    C_IDLE,
    C_SHIFT
  } cap_state_t;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } ser_state_t;

endpackage

// File: rtl/adc_in_sync.sv
// Parameterized 2-flop synchronizer with optional edge-pulse output.
// Ports: clk, rst (sync, active-high), d (async in), q (synced level,
// or one-cycle edge pulses when EDGES=1; FALL_MASK bit picks falling).
import adc_frame_pkg::*;

module adc_in_sync #(
  parameter int             W         = 1,
  parameter bit             EDGES     = 1'b0,
  parameter logic [W-1:0]   FALL_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  if (EDGES) begin : g_edge
    logic [W-1:0] s3;

    always_ff @(posedge clk) begin
      if (rst) s3 <= '0;
      else     s3 <= s2;
    end

    // Reset value 0 means a line idling high never fakes a falling edge.
    assign q = (FALL_MASK & s3 & ~s2) |
               (~FALL_MASK & s2 & ~s3);
  end else begin : g_lvl
    assign q = s2;
  end

endmodule

// File: rtl/adc_frame_serializer.sv
// Captures one AD7768-4 frame (4 serial channels) and re-emits it as a
// 1-bit stream with per-bit FIFO write strobe; double-buffered.
// Ports: clk, rst, adc_dclk, adc_n_drdy, adc_ch0..3, acq_en, fifo_full,
// data_out, fifo_wr_en, frame_drop_cnt, sync_err.
// Option: ADC_FRAME_HEADER_STRIP_EN drops the 8 header MSBs per channel.
import adc_frame_pkg::*;

module adc_frame_serializer #(
  parameter int CH_BITS = CH_BITS_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_dclk,
  input  logic             adc_n_drdy,
  input  logic             adc_ch0,
  input  logic             adc_ch1,
  input  logic             adc_ch2,
  input  logic             adc_ch3,
  input  logic             acq_en,
  input  logic             fifo_full,
  output logic             data_out,
  output logic             fifo_wr_en,
  output logic [CNT_W-1:0] frame_drop_cnt,
  output logic             sync_err
);

`ifdef ADC_FRAME_HEADER_STRIP_EN
  localparam int OB = CH_BITS - HDR_BITS;
`else
  localparam int OB = CH_BITS;
`endif
  localparam int OUT_BITS = OB * N_CH;
  localparam int BW       = $clog2(CH_BITS + 1);
  localparam int EW       = $clog2(OUT_BITS + 1);

  logic [1:0]      ev;
  logic            dclk_rise;
  logic            drdy_fall;
  logic [N_CH-1:0] din;

  adc_in_sync #(
    .W         (2),
    .EDGES     (1'b1),
    .FALL_MASK (2'b01)
  ) u_ctl (
    .clk (clk),
    .rst (rst),
    .d   ({adc_dclk, adc_n_drdy}),
    .q   (ev)
  );

  assign dclk_rise = ev[1];
  assign drdy_fall = ev[0];

  adc_in_sync #(
    .W     (N_CH),
    .EDGES (1'b0)
  ) u_dat (
    .clk (clk),
    .rst (rst),
    .d   ({adc_ch3, adc_ch2, adc_ch1, adc_ch0}),
    .q   (din)
  );

  // Capture side
  cap_state_t     c_state;
  cap_state_t     c_next;
  logic [BW-1:0]  bit_cnt;
  logic [OB-1:0]  sh [N_CH];
  logic           cap_clr;
  logic           cap_shift;
  logic           cap_done;
  logic           cap_err;
  logic           done_q;

  always_comb begin
    c_next    = c_state;
    cap_clr   = 1'b0;
    cap_shift = 1'b0;
    cap_done  = 1'b0;
    cap_err   = 1'b0;
    unique case (c_state)
      C_IDLE: begin
        if (drdy_fall) begin
          cap_clr = 1'b1;
          c_next  = C_SHIFT;
        end
      end
      C_SHIFT: begin
        if (drdy_fall) begin
          cap_clr = 1'b1;
          cap_err = 1'b1;
        end else if (dclk_rise) begin
          cap_shift = 1'b1;
          if (bit_cnt == BW'(CH_BITS - 1)) begin
            cap_done = 1'b1;
            c_next   = C_IDLE;
          end
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  // With header strip the registers are only OB wide, so the header
  // bits simply fall off the top as the data bits shift in.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_state  <= C_IDLE;
      bit_cnt  <= '0;
      done_q   <= 1'b0;
      sync_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) sh[i] <= '0;
    end else begin
      c_state <= c_next;
      done_q  <= cap_done;
      if (cap_err) sync_err <= 1'b1;
      if (cap_clr)        bit_cnt <= '0;
      else if (cap_shift) bit_cnt <= bit_cnt + 1'b1;
      if (cap_shift)
        for (int i = 0; i < N_CH; i++)
          sh[i] <= {sh[i][OB-2:0], din[i]};
    end
  end

  // Handoff / serializer side
  ser_state_t          s_state;
  ser_state_t          s_next;
  logic [OUT_BITS-1:0] out_sh;
  logic [OUT_BITS-1:0] frame;
  logic [EW-1:0]       e_cnt;
  logic                ser_last;
  logic                busy;
  logic                accept;
  logic                drop;

  assign ser_last = (s_state == S_EMIT) &&
                    (e_cnt == EW'(OUT_BITS - 1));
  // Emitting the last bit frees the shifter for a back-to-back frame.
  assign busy     = (s_state == S_EMIT) && !ser_last;
  assign accept   = done_q && acq_en && !fifo_full && !busy;
  assign drop     = done_q && acq_en && (fifo_full || busy);

  always_comb begin
    frame = '0;
    for (int i = 0; i < N_CH; i++)
      frame[(N_CH-1-i)*OB +: OB] = sh[i];
  end

  always_comb begin
    s_next = s_state;
    unique case (s_state)
      S_IDLE: if (accept) s_next = S_EMIT;
      S_EMIT: if (ser_last && !accept) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state <= S_IDLE;
      out_sh  <= '0;
      e_cnt   <= '0;
    end else begin
      s_state <= s_next;
      if (accept) begin
        out_sh <= frame;
        e_cnt  <= '0;
      end else if (s_state == S_EMIT) begin
        out_sh <= out_sh << 1;
        e_cnt  <= e_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      frame_drop_cnt <= '0;
    else if (drop && (frame_drop_cnt != '1))
      frame_drop_cnt <= frame_drop_cnt + 1'b1;
  end

  assign fifo_wr_en = (s_state == S_EMIT);
  assign data_out   = fifo_wr_en & out_sh[OUT_BITS-1];

endmodule
